// File: rtl/decode_pkg.sv
// Shared definitions for the instruction decode pipeline: field positions, bundle layout, default masks.
// Latency: none (package only).
// Backpressure: not applicable.
package decode_pkg;

  // Default geometry of the instruction word and decoded bundle.
  localparam int DEF_INSTR_W = 16;
  localparam int DEF_OPC_W   = 4;
  localparam int DEF_REG_AW  = 3;
  localparam int DEF_IMM_W   = 8;
  localparam int DEF_DATA_W  = 16;
  localparam int DEF_CNT_W   = 16;

  // Per-opcode attribute masks; bit k describes opcode k.
  localparam logic [(1 << DEF_OPC_W)-1:0] DEF_ILLEGAL_MASK = 16'h0000;
  localparam logic [(1 << DEF_OPC_W)-1:0] DEF_IMM_MASK     = 16'h0000;

  // Field positions are packed from the MSB down: opcode, rD, flag, rA, rB.
  function automatic int opc_lsb(input int instr_w, input int opc_w);
    return instr_w - opc_w;
  endfunction

  function automatic int rd_lsb(input int instr_w, input int opc_w, input int reg_aw);
    return opc_lsb(instr_w, opc_w) - reg_aw;
  endfunction

  function automatic int flag_pos(input int instr_w, input int opc_w, input int reg_aw);
    return rd_lsb(instr_w, opc_w, reg_aw) - 1;
  endfunction

  function automatic int ra_lsb(input int instr_w, input int opc_w, input int reg_aw);
    return flag_pos(instr_w, opc_w, reg_aw) - reg_aw;
  endfunction

  function automatic int rb_lsb(input int instr_w, input int opc_w, input int reg_aw);
    return ra_lsb(instr_w, opc_w, reg_aw) - reg_aw;
  endfunction

  // Default field positions: opcode 15:12, rD 11:9, flag 8, rA 7:5, rB 4:2.
  localparam int DEF_OPC_LSB  = opc_lsb(DEF_INSTR_W, DEF_OPC_W);
  localparam int DEF_RD_LSB   = rd_lsb(DEF_INSTR_W, DEF_OPC_W, DEF_REG_AW);
  localparam int DEF_FLAG_POS = flag_pos(DEF_INSTR_W, DEF_OPC_W, DEF_REG_AW);
  localparam int DEF_RA_LSB   = ra_lsb(DEF_INSTR_W, DEF_OPC_W, DEF_REG_AW);
  localparam int DEF_RB_LSB   = rb_lsb(DEF_INSTR_W, DEF_OPC_W, DEF_REG_AW);

  // Decoded bundle at the default geometry; the top module mirrors this
  // layout with its own parameterised widths.
  typedef struct packed {
    logic [DEF_OPC_W-1:0]  opcode;
    logic [DEF_REG_AW-1:0] rd;
    logic [DEF_REG_AW-1:0] ra;
    logic [DEF_REG_AW-1:0] rb;
    logic                  flag;
    logic [DEF_IMM_W-1:0]  imm;
    logic [DEF_DATA_W-1:0] imm_ext;
    logic                  imm_sel;
    logic                  illegal;
  } decode_bundle_t;

endpackage

// File: rtl/decode_skid_buf.sv
// Generic 2-entry valid/ready skid buffer: main output register plus one skid register.
// Latency: 1 cycle from input transfer to out_valid.
// Backpressure: in_ready is registered (!skid.valid); no combinational path from out_ready.
//
// Ports: clock/reset_n (async active-low), flush (sync clear of both valids),
//        in_valid/in_ready/in_data (upstream), out_valid/out_ready/out_data (downstream).
module decode_skid_buf #(
  parameter int W = 8
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  logic         m_vld;
  logic         s_vld;
  logic [W-1:0] m_dat;
  logic [W-1:0] s_dat;
  logic         drain;
  logic         in_xfer;

  assign drain   = m_vld & out_ready;
  assign in_xfer = in_valid & ~s_vld;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      m_vld <= 1'b0;
      s_vld <= 1'b0;
      m_dat <= '0;
      s_dat <= '0;
    end else if (flush) begin
      // Only the valids clear; data registers keep their last contents.
      m_vld <= 1'b0;
      s_vld <= 1'b0;
    end else if (s_vld) begin
      // Skid full implies main full; in_ready is low so no input this cycle.
      if (drain) begin
        m_dat <= s_dat;
        s_vld <= 1'b0;
      end
    end else if (!m_vld || drain) begin
      m_vld <= in_xfer;
      if (in_xfer) begin
        m_dat <= in_data;
      end
    end else if (in_xfer) begin
      // Main stalled: park the bundle so in_ready can drop next cycle.
      s_vld <= 1'b1;
      s_dat <= in_data;
    end
  end

  assign in_ready  = ~s_vld;
  assign out_valid = m_vld;
  assign out_data  = m_dat;

endmodule

// File: rtl/instr_decode_pipe.sv
// Flow-controlled instruction decoder: field split, immediate extension, opcode attribute lookup, transfer counter.
// Latency: 1 cycle from input transfer to out_valid.
// Backpressure: 2-entry skid buffer; in_ready is registered, outputs hold while out_valid && !out_ready.
//
// Ports: clock, reset_n (async active-low), flush (sync clear, counter kept),
//        in_valid/in_ready/instruct (fetch side), out_valid/out_ready (issue side),
//        opcode/rDadrs/flag/rAadrs/rBadrs/imm/imm_ext/imm_sel/illegal (decoded bundle),
//        dec_count (accepted output transfers, wrapping).
module instr_decode_pipe
  import decode_pkg::*;
#(
  parameter int                       INSTR_W      = DEF_INSTR_W,
  parameter int                       OPC_W        = DEF_OPC_W,
  parameter int                       REG_AW       = DEF_REG_AW,
  parameter int                       IMM_W        = DEF_IMM_W,
  parameter int                       DATA_W       = DEF_DATA_W,
  parameter logic [(1 << OPC_W)-1:0]  ILLEGAL_MASK = DEF_ILLEGAL_MASK,
  parameter logic [(1 << OPC_W)-1:0]  IMM_MASK     = DEF_IMM_MASK,
  parameter int                       CNT_W        = DEF_CNT_W
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [INSTR_W-1:0] instruct,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [OPC_W-1:0]   opcode,
  output logic [REG_AW-1:0]  rDadrs,
  output logic               flag,
  output logic [REG_AW-1:0]  rAadrs,
  output logic [REG_AW-1:0]  rBadrs,
  output logic [IMM_W-1:0]   imm,
  output logic [DATA_W-1:0]  imm_ext,
  output logic               imm_sel,
  output logic               illegal,
  output logic [CNT_W-1:0]   dec_count
);

  localparam int OPC_LSB  = opc_lsb(INSTR_W, OPC_W);
  localparam int RD_LSB   = rd_lsb(INSTR_W, OPC_W, REG_AW);
  localparam int FLAG_POS = flag_pos(INSTR_W, OPC_W, REG_AW);
  localparam int RA_LSB   = ra_lsb(INSTR_W, OPC_W, REG_AW);
  localparam int RB_LSB   = rb_lsb(INSTR_W, OPC_W, REG_AW);

  // Reject geometries where the fields cannot fit or the extension would truncate.
  generate
    if (INSTR_W < OPC_W + 3 * REG_AW + 1) begin : g_bad_fields
      $error("instr_decode_pipe: INSTR_W too small for opcode + 3 register fields + flag");
    end
    if (IMM_W > INSTR_W) begin : g_bad_imm
      $error("instr_decode_pipe: IMM_W exceeds INSTR_W");
    end
    if (DATA_W < IMM_W) begin : g_bad_data
      $error("instr_decode_pipe: DATA_W must be >= IMM_W");
    end
  endgenerate

  typedef struct packed {
    logic [OPC_W-1:0]  opcode;
    logic [REG_AW-1:0] rd;
    logic [REG_AW-1:0] ra;
    logic [REG_AW-1:0] rb;
    logic              flag;
    logic [IMM_W-1:0]  imm;
    logic [DATA_W-1:0] imm_ext;
    logic              imm_sel;
    logic              illegal;
  } bundle_t;

  bundle_t dec;
  bundle_t q;
  logic    xfer_out;

  always_comb begin
    dec         = '0;
    dec.opcode  = instruct[OPC_LSB +: OPC_W];
    dec.rd      = instruct[RD_LSB +: REG_AW];
    dec.flag    = instruct[FLAG_POS];
    dec.ra      = instruct[RA_LSB +: REG_AW];
    dec.rb      = instruct[RB_LSB +: REG_AW];
    dec.imm     = instruct[IMM_W-1:0];
    // Fill every bit with the sign (only when flag is set), then overlay the
    // raw immediate; this also works when DATA_W == IMM_W.
    dec.imm_ext = {DATA_W{dec.flag & dec.imm[IMM_W-1]}};
    dec.imm_ext[IMM_W-1:0] = dec.imm;
    dec.imm_sel = IMM_MASK[dec.opcode];
    dec.illegal = ILLEGAL_MASK[dec.opcode];
  end

  decode_skid_buf #(
    .W($bits(bundle_t))
  ) u_skid (
    .clock    (clock),
    .reset_n  (reset_n),
    .flush    (flush),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (dec),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (q)
  );

  assign xfer_out = out_valid & out_ready;

  // Counts transfers, including one that completes in a flush cycle.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      dec_count <= '0;
    end else if (xfer_out) begin
      dec_count <= dec_count + CNT_W'(1);
    end
  end

  assign opcode  = q.opcode;
  assign rDadrs  = q.rd;
  assign flag    = q.flag;
  assign rAadrs  = q.ra;
  assign rBadrs  = q.rb;
  assign imm     = q.imm;
  assign imm_ext = q.imm_ext;
  assign imm_sel = q.imm_sel;
  assign illegal = q.illegal;

endmodule

// File: tb/tb_instr_decode_pipe.sv
// Testbench for instr_decode_pipe with opcode F illegal and opcode 4 immediate-selecting.
// Latency: reference model is a queue of expected bundles; occupancy predicts the handshake.
// Backpressure: stimulus toggles out_ready and flush randomly in the final scenario.
module tb_instr_decode_pipe;
  import decode_pkg::*;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] instruct = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [3:0]  opcode;
  logic [2:0]  rDadrs;
  logic        flag;
  logic [2:0]  rAadrs;
  logic [2:0]  rBadrs;
  logic [7:0]  imm;
  logic [15:0] imm_ext;
  logic        imm_sel;
  logic        illegal;
  logic [15:0] dec_count;

  instr_decode_pipe #(
    .ILLEGAL_MASK(16'h8000),
    .IMM_MASK    (16'h0010)
  ) dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .flush    (flush),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .instruct (instruct),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .opcode   (opcode),
    .rDadrs   (rDadrs),
    .flag     (flag),
    .rAadrs   (rAadrs),
    .rBadrs   (rBadrs),
    .imm      (imm),
    .imm_ext  (imm_ext),
    .imm_sel  (imm_sel),
    .illegal  (illegal),
    .dec_count(dec_count)
  );

  always #5 clock = ~clock;

  int             n_vec = 0;
  int             n_err = 0;
  decode_bundle_t exp_q[$];
  logic [15:0]    cnt_model = '0;
  logic           out_fired;
  logic           in_fired;
  logic           dut_fired;
  decode_bundle_t out_got;
  decode_bundle_t out_exp;

  // Reference decode straight from the field layout, using arithmetic on the word.
  function automatic decode_bundle_t ref_decode(input logic [15:0] w);
    decode_bundle_t b;
    int unsigned    v;
    v         = w;
    b.opcode  = 4'(v / 4096);
    b.rd      = 3'((v / 512) % 8);
    b.flag    = 1'((v / 256) % 2);
    b.ra      = 3'((v / 32) % 8);
    b.rb      = 3'((v / 4) % 8);
    b.imm     = 8'(v % 256);
    b.imm_ext = (b.flag && (v % 256) >= 128) ? 16'((v % 256) + 32'hFF00) : 16'(v % 256);
    b.illegal = (b.opcode == 4'hF);
    b.imm_sel = (b.opcode == 4'h4);
    return b;
  endfunction

  function automatic decode_bundle_t dut_bundle();
    decode_bundle_t b;
    b.opcode  = opcode;
    b.rd      = rDadrs;
    b.ra      = rAadrs;
    b.rb      = rBadrs;
    b.flag    = flag;
    b.imm     = imm;
    b.imm_ext = imm_ext;
    b.imm_sel = imm_sel;
    b.illegal = illegal;
    return b;
  endfunction

  // One clock: drive inputs, advance the model, land 1 time unit after the edge.
  task automatic cycle(input logic iv, input logic [15:0] w, input logic ordy, input logic fl);
    int occ;
    in_valid  = iv;
    instruct  = w;
    out_ready = ordy;
    flush     = fl;
    occ       = exp_q.size();
    out_fired = ordy && (occ > 0);
    in_fired  = iv && (occ < 2) && !fl;
    dut_fired = out_valid && ordy;
    out_got   = dut_bundle();
    out_exp   = '0;
    if (out_fired) begin
      out_exp   = exp_q.pop_front();
      cnt_model = cnt_model + 16'd1;
    end
    if (fl) exp_q.delete();
    else if (in_fired) exp_q.push_back(ref_decode(w));
    @(posedge clock);
    #1;
    in_valid = 1'b0;
    flush    = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
    n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
    n_vec++; if (dec_count !== 16'd0) begin n_err++; $display("FAIL reset_count got=%0d want=0", dec_count); end
    n_vec++; if (dut_bundle() !== '0) begin n_err++; $display("FAIL reset_data got=%h want=0", dut_bundle()); end
    reset_n = 1'b1;
    exp_q.delete();
    cnt_model = '0;
    @(posedge clock);
    #1;
  endtask

  task automatic test_basic();
    cycle(1'b1, 16'h5A7C, 1'b1, 1'b0);
    n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL basic_valid got=%b want=1", out_valid); end
    n_vec++; if (opcode !== 4'd5) begin n_err++; $display("FAIL basic_opcode got=%0d want=5", opcode); end
    n_vec++; if (rDadrs !== 3'd5) begin n_err++; $display("FAIL basic_rd got=%0d want=5", rDadrs); end
    n_vec++; if (flag !== 1'b0) begin n_err++; $display("FAIL basic_flag got=%b want=0", flag); end
    n_vec++; if (rAadrs !== 3'd3) begin n_err++; $display("FAIL basic_ra got=%0d want=3", rAadrs); end
    n_vec++; if (rBadrs !== 3'd7) begin n_err++; $display("FAIL basic_rb got=%0d want=7", rBadrs); end
    n_vec++; if (imm !== 8'h7C) begin n_err++; $display("FAIL basic_imm got=%h want=7c", imm); end
    n_vec++; if (imm_ext !== 16'h007C) begin n_err++; $display("FAIL basic_imm_ext got=%h want=007c", imm_ext); end
    n_vec++; if (dec_count !== 16'd0) begin n_err++; $display("FAIL basic_count0 got=%0d want=0", dec_count); end
    cycle(1'b0, 16'h0000, 1'b1, 1'b0);
    n_vec++; if (dec_count !== 16'd1) begin n_err++; $display("FAIL basic_count1 got=%0d want=1", dec_count); end
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL basic_empty got=%b want=0", out_valid); end
  endtask

  task automatic test_imm_ext();
    cycle(1'b1, 16'h3185, 1'b1, 1'b0);
    n_vec++; if (imm_ext !== 16'hFF85) begin n_err++; $display("FAIL sext got=%h want=ff85", imm_ext); end
    n_vec++; if (flag !== 1'b1) begin n_err++; $display("FAIL sext_flag got=%b want=1", flag); end
    cycle(1'b1, 16'h3085, 1'b1, 1'b0);
    n_vec++; if (imm_ext !== 16'h0085) begin n_err++; $display("FAIL zext got=%h want=0085", imm_ext); end
    n_vec++; if (out_got !== out_exp) begin n_err++; $display("FAIL sext_xfer got=%h want=%h", out_got, out_exp); end
    cycle(1'b0, 16'h0000, 1'b1, 1'b0);
    n_vec++; if (out_got !== out_exp) begin n_err++; $display("FAIL zext_xfer got=%h want=%h", out_got, out_exp); end
  endtask

  task automatic test_back_to_back();
    logic [15:0] w;
    logic [15:0] cnt0;
    int          nv;
    cnt0 = dec_count;
    nv   = 0;
    for (int i = 0; i < 8; i++) begin
      n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL b2b_in_ready beat=%0d got=%b want=1", i, in_ready); end
      w = 16'($urandom);
      cycle(1'b1, w, 1'b1, 1'b0);
      if (out_valid === 1'b1) nv++;
      n_vec++; if (dut_bundle() !== ref_decode(w)) begin n_err++; $display("FAIL b2b_data beat=%0d got=%h want=%h", i, dut_bundle(), ref_decode(w)); end
    end
    cycle(1'b0, 16'h0000, 1'b1, 1'b0);
    n_vec++; if (nv !== 8) begin n_err++; $display("FAIL b2b_valid_cycles got=%0d want=8", nv); end
    n_vec++; if (dec_count !== 16'(cnt0 + 16'd8)) begin n_err++; $display("FAIL b2b_count got=%0d want=%0d", dec_count, cnt0 + 16'd8); end
  endtask

  task automatic test_backpressure();
    logic [15:0] w0, w1, w2;
    logic        sent;
    int          douts;
    w0 = 16'($urandom); w1 = 16'($urandom); w2 = 16'($urandom);
    cycle(1'b1, w0, 1'b0, 1'b0);
    n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL bp_ready1 got=%b want=1", in_ready); end
    cycle(1'b1, w1, 1'b0, 1'b0);
    n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL bp_ready2 got=%b want=0", in_ready); end
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, w2, 1'b0, 1'b0);
      n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL bp_hold_ready cyc=%0d got=%b want=0", i, in_ready); end
      n_vec++; if (out_valid !== 1'b1 || dut_bundle() !== ref_decode(w0)) begin
        n_err++; $display("FAIL bp_stable cyc=%0d got=%h want=%h", i, dut_bundle(), ref_decode(w0));
      end
    end
    sent  = 1'b0;
    douts = 0;
    for (int i = 0; i < 8; i++) begin
      cycle(!sent, w2, 1'b1, 1'b0);
      if (in_fired) sent = 1'b1;
      if (dut_fired) douts++;
      if (out_fired) begin
        n_vec++; if (out_got !== out_exp) begin n_err++; $display("FAIL bp_drain cyc=%0d got=%h want=%h", i, out_got, out_exp); end
      end
    end
    n_vec++; if (douts !== 3) begin n_err++; $display("FAIL bp_drain_count got=%0d want=3", douts); end
  endtask

  task automatic test_masks();
    cycle(1'b1, {4'hF, 12'($urandom)}, 1'b1, 1'b0);
    n_vec++; if (illegal !== 1'b1) begin n_err++; $display("FAIL mask_f_illegal got=%b want=1", illegal); end
    n_vec++; if (imm_sel !== 1'b0) begin n_err++; $display("FAIL mask_f_imm_sel got=%b want=0", imm_sel); end
    cycle(1'b1, {4'h4, 12'($urandom)}, 1'b1, 1'b0);
    n_vec++; if (illegal !== 1'b0) begin n_err++; $display("FAIL mask_4_illegal got=%b want=0", illegal); end
    n_vec++; if (imm_sel !== 1'b1) begin n_err++; $display("FAIL mask_4_imm_sel got=%b want=1", imm_sel); end
    cycle(1'b0, 16'h0000, 1'b1, 1'b0);
  endtask

  task automatic test_flush_reset();
    decode_bundle_t hold;
    logic [15:0]    cnt0;
    cycle(1'b1, 16'($urandom), 1'b0, 1'b0);
    cycle(1'b1, 16'($urandom), 1'b0, 1'b0);
    n_vec++; if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
      n_err++; $display("FAIL flush_fill got=%b%b want=01", in_ready, out_valid);
    end
    hold = dut_bundle();
    cnt0 = dec_count;
    cycle(1'b1, 16'($urandom), 1'b0, 1'b1);
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL flush_valid got=%b want=0", out_valid); end
    n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL flush_ready got=%b want=1", in_ready); end
    n_vec++; if (dec_count !== cnt0) begin n_err++; $display("FAIL flush_count got=%0d want=%0d", dec_count, cnt0); end
    n_vec++; if (dut_bundle() !== hold) begin n_err++; $display("FAIL flush_data_kept got=%h want=%h", dut_bundle(), hold); end
    cycle(1'b0, 16'h0000, 1'b1, 1'b0);
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL flush_drop got=%b want=0", out_valid); end
    // Flush while an output transfer completes: that transfer still counts.
    cycle(1'b1, 16'($urandom), 1'b0, 1'b0);
    cycle(1'b1, 16'($urandom), 1'b0, 1'b0);
    cnt0 = dec_count;
    cycle(1'b0, 16'h0000, 1'b1, 1'b1);
    n_vec++; if (dec_count !== 16'(cnt0 + 16'd1)) begin n_err++; $display("FAIL flush_xfer_count got=%0d want=%0d", dec_count, cnt0 + 16'd1); end
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL flush_xfer_valid got=%b want=0", out_valid); end
    // Refill, then pull reset between edges.
    cycle(1'b1, 16'($urandom) | 16'h0100, 1'b0, 1'b0);
    cycle(1'b1, 16'($urandom), 1'b0, 1'b0);
    #2;
    reset_n = 1'b0;
    #1;
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL arst_valid got=%b want=0", out_valid); end
    n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL arst_ready got=%b want=1", in_ready); end
    n_vec++; if (dec_count !== 16'd0) begin n_err++; $display("FAIL arst_count got=%0d want=0", dec_count); end
    n_vec++; if (dut_bundle() !== '0) begin n_err++; $display("FAIL arst_data got=%h want=0", dut_bundle()); end
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    exp_q.delete();
    cnt_model = '0;
    @(posedge clock);
    #1;
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      n_vec++; if (in_ready !== (exp_q.size() < 2)) begin
        n_err++; $display("FAIL rnd_in_ready cyc=%0d got=%b want=%b", i, in_ready, exp_q.size() < 2);
      end
      n_vec++; if (out_valid !== (exp_q.size() > 0)) begin
        n_err++; $display("FAIL rnd_out_valid cyc=%0d got=%b want=%b", i, out_valid, exp_q.size() > 0);
      end
      if (exp_q.size() > 0) begin
        n_vec++; if (dut_bundle() !== exp_q[0]) begin
          n_err++; $display("FAIL rnd_data cyc=%0d got=%h want=%h", i, dut_bundle(), exp_q[0]);
        end
      end
      n_vec++; if (dec_count !== cnt_model) begin
        n_err++; $display("FAIL rnd_count cyc=%0d got=%0d want=%0d", i, dec_count, cnt_model);
      end
      cycle(1'($urandom_range(0, 3) != 0), 16'($urandom),
            1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 31) == 0));
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    #1;
    test_reset();
    test_basic();
    test_imm_ext();
    test_back_to_back();
    test_backpressure();
    test_masks();
    test_flush_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
